// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N systolic array: streams SRAM rows in, advances the array,
// and walks the output diagonals with downstream backpressure, over one or more tiles.
module systolic_ctrl #(
    parameter int unsigned ARRAY_SIZE  = 8,
    parameter int unsigned CYCLE_BITS  = 9,
    parameter int unsigned MATRIX_BITS = 6,
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned TILE_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   srstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TILE_BITS-1:0]   tile_num,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic                   out_ready,
    output logic                   sram_ren,
    output logic [ADDR_BITS-1:0]   sram_raddr,
    output logic                   alu_start,
    output logic [CYCLE_BITS-1:0]  cycle_num,
    output logic [MATRIX_BITS-1:0] matrix_index,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned LAST = 3 * ARRAY_SIZE;

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e                 state_q;
    logic [TILE_BITS-1:0]   tile_q;
    logic [TILE_BITS-1:0]   tiles_q;
    logic [ADDR_BITS-1:0]   base_q;

    logic                   accept;
    logic                   at_last;
    logic                   more_tiles;
    logic [CYCLE_BITS-1:0]  cyc_adv;
    logic [TILE_BITS-1:0]   tile_adv;
    logic [ADDR_BITS-1:0]   addr_adv;
    logic                   ren_adv;
    logic                   ov_adv;
    logic [MATRIX_BITS-1:0] mi_adv;

    // Values the registered outputs take when the current array cycle is accepted.
    always_comb begin
        accept     = !out_valid || out_ready;
        at_last    = (cycle_num == CYCLE_BITS'(LAST));
        // tile_q < tiles_q always holds, so tile_q+1 cannot overflow here
        more_tiles = ((tile_q + 1'b1) != tiles_q);
        cyc_adv    = at_last ? '0 : cycle_num + 1'b1;
        tile_adv   = at_last ? tile_q + 1'b1 : tile_q;
        addr_adv   = base_q + ADDR_BITS'(tile_adv) * ADDR_BITS'(ARRAY_SIZE)
                   + ADDR_BITS'(cyc_adv);
        ren_adv    = (cyc_adv < CYCLE_BITS'(ARRAY_SIZE));
        ov_adv     = (cyc_adv >= CYCLE_BITS'(ARRAY_SIZE + 2));
        mi_adv     = MATRIX_BITS'(cyc_adv - CYCLE_BITS'(ARRAY_SIZE + 2));
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q      <= StIdle;
            tile_q       <= '0;
            tiles_q      <= '0;
            base_q       <= '0;
            sram_ren     <= 1'b0;
            sram_raddr   <= '0;
            alu_start    <= 1'b0;
            cycle_num    <= '0;
            matrix_index <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_q    <= StRun;
                        busy       <= 1'b1;
                        tile_q     <= '0;
                        tiles_q    <= (tile_num == '0) ? TILE_BITS'(1) : tile_num;
                        base_q     <= base_addr;
                        cycle_num  <= '0;
                        alu_start  <= 1'b1;
                        sram_ren   <= 1'b1;
                        sram_raddr <= base_addr;
                        out_valid  <= 1'b0;
                    end
                end
                StRun, StHold: begin
                    if (abort) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        alu_start <= 1'b0;
                        sram_ren  <= 1'b0;
                        out_valid <= 1'b0;
                        cycle_num <= '0;
                    end else if (!accept) begin
                        // diagonal not taken: freeze everything, stop the array
                        state_q   <= StHold;
                        alu_start <= 1'b0;
                    end else if (at_last && !more_tiles) begin
                        state_q   <= StDone;
                        alu_start <= 1'b0;
                        sram_ren  <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_q   <= StRun;
                        tile_q    <= tile_adv;
                        cycle_num <= cyc_adv;
                        alu_start <= 1'b1;
                        sram_ren  <= ren_adv;
                        out_valid <= ov_adv;
                        if (ren_adv) sram_raddr <= addr_adv;
                        if (ov_adv) matrix_index <= mi_adv;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized bench for systolic_ctrl; expectations come from a step-indexed job model.
module tb_systolic_ctrl;

    localparam int N = 8;
    localparam int L = 3 * N;

    logic       clk = 1'b0;
    logic       srstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] tile_num = 8'd1;
    logic [9:0] base_addr = 10'd0;
    logic       sram_ren;
    logic [9:0] sram_raddr;
    logic       alu_start;
    logic [8:0] cycle_num;
    logic [5:0] matrix_index;
    logic       out_valid;
    logic       busy;
    logic       done;

    systolic_ctrl dut (
        .clk          (clk),
        .srstn        (srstn),
        .start        (start),
        .abort        (abort),
        .tile_num     (tile_num),
        .base_addr    (base_addr),
        .out_ready    (out_ready),
        .sram_ren     (sram_ren),
        .sram_raddr   (sram_raddr),
        .alu_start    (alu_start),
        .cycle_num    (cycle_num),
        .matrix_index (matrix_index),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int alu_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Job model: a job is a flat sequence of tiles*(L+1) array steps.
    int m_phase = 0;  // 0 idle, 1 active, 2 done pulse
    int m_step = 0;
    int m_total = 0;
    int m_base = 0;
    bit m_stall = 0;
    int m_raddr = 0;
    int m_mi = 0;

    function automatic int m_c();
        return m_step % (L + 1);
    endfunction

    function automatic void model_edge();
        case (m_phase)
            0: if (start && !abort) begin
                m_phase = 1;
                m_step  = 0;
                m_total = ((tile_num == 0) ? 1 : int'(tile_num)) * (L + 1);
                m_base  = int'(base_addr);
                m_stall = 0;
            end
            1: if (abort) m_phase = 0;
               else if (m_c() >= N + 2 && !out_ready) m_stall = 1;
               else begin
                   m_stall = 0;
                   m_step++;
                   if (m_step == m_total) m_phase = 2;
               end
            default: m_phase = 0;
        endcase
        if (m_phase == 1 && m_c() < N) m_raddr = (m_base + (m_step / (L + 1)) * N + m_c()) % 1024;
        if (m_phase == 1 && m_c() >= N + 2) m_mi = m_c() - N - 2;
    endfunction

    task automatic check_outputs();
        bit act;
        int c;
        act = (m_phase == 1);
        c = m_c();
        check("busy", int'(busy), int'(m_phase != 0));
        check("done", int'(done), int'(m_phase == 2));
        check("alu_start", int'(alu_start), int'(act && !m_stall));
        check("sram_ren", int'(sram_ren), int'(act && c < N));
        check("sram_raddr", int'(sram_raddr), m_raddr);
        check("out_valid", int'(out_valid), int'(act && c >= N + 2));
        if (act) check("cycle_num", int'(cycle_num), c);
        if (act && c >= N + 2) check("matrix_index", int'(matrix_index), m_mi);
    endtask

    // Drive inputs for one clock, advance the model, sample at the falling edge.
    task automatic step(input bit s, input bit a, input bit r);
        start = s;
        abort = a;
        out_ready = r;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (alu_start) alu_cnt++;
        if (done) done_cnt++;
        if (busy && !alu_start && !done) stall_cnt++;
        check_outputs();
    endtask

    task automatic run_until_c(input int target);
        int k = 0;
        while (!(m_phase == 1 && m_c() == target) && k < 200) begin
            step(1'b0, 1'b0, 1'b1);
            k++;
        end
        check("reach_cycle", int'(m_phase == 1 && m_c() == target), 1);
    endtask

    task automatic run_to_idle(input bit rnd);
        int k = 0;
        while (m_phase != 0 && k < 2000) begin
            if (rnd) begin
                tile_num  = 8'($urandom);
                base_addr = 10'($urandom);
                step(($urandom % 4) == 0, ($urandom % 300) == 0, ($urandom % 5) != 0);
            end else begin
                step(1'b0, 1'b0, 1'b1);
            end
            k++;
        end
        check("job_ends", m_phase, 0);
    endtask

    initial begin
        #2;
        check("rst_busy", int'(busy), 0);
        check("rst_alu", int'(alu_start), 0);
        check("rst_raddr", int'(sram_raddr), 0);
        srstn = 1'b1;
        @(negedge clk);
        check_outputs();

        // single tile, reads 0x010..0x017
        tile_num = 8'd1; base_addr = 10'h010;
        done_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1'b0);
        check("single_done_pulses", done_cnt, 1);

        // three tiles crossing the address wrap
        tile_num = 8'd3; base_addr = 10'h3F8;
        alu_cnt = 0; done_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1'b0);
        check("wrap_alu_cycles", alu_cnt, 75);
        check("wrap_done_pulses", done_cnt, 1);

        // backpressure for 5 cycles at diagonal 3
        tile_num = 8'd1; base_addr = 10'h100;
        stall_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        run_until_c(N + 2 + 3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        run_to_idle(1'b0);
        check("stall_cycles", stall_cnt, 5);

        // abort at cycle 12, then a fresh job
        done_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        run_until_c(12);
        step(1'b0, 1'b1, 1'b1);
        check("abort_busy", int'(busy), 0);
        check("abort_done_pulses", done_cnt, 0);
        tile_num = 8'd2; base_addr = 10'h020;
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1'b0);

        // start with abort in idle is ignored
        step(1'b1, 1'b1, 1'b1);
        check("start_abort_idle", int'(busy), 0);

        // asynchronous reset mid-job
        tile_num = 8'd2; base_addr = 10'h055;
        step(1'b1, 1'b0, 1'b1);
        run_until_c(5);
        #1 srstn = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_ren", int'(sram_ren), 0);
        check("arst_raddr", int'(sram_raddr), 0);
        check("arst_cycle", int'(cycle_num), 0);
        check("arst_alu", int'(alu_start), 0);
        m_phase = 0; m_stall = 0; m_raddr = 0; m_mi = 0;
        #1 srstn = 1'b1;
        step(1'b0, 1'b0, 1'b1);

        // tile_num of zero runs a single tile
        tile_num = 8'd0; base_addr = 10'h3FC;
        alu_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        run_to_idle(1'b0);
        check("zero_tiles_alu", alu_cnt, L + 1);

        // randomized jobs with backpressure, stray starts and rare aborts
        for (int j = 0; j < 30; j++) begin
            tile_num  = 8'($urandom_range(0, 3));
            base_addr = (($urandom % 3) == 0) ? 10'h3F8 : 10'($urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--) step(1'b0, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b1);
            run_to_idle(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
